// File: rtl/ir_rx_pkg.sv
// rtl/ir_rx_pkg.sv - IR receiver shared types, tick thresholds and register offsets.
package ir_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_GAP,
    ST_CARSEL,
    ST_BITGAP,
    ST_BIT,
    ST_DONE
  } ir_state_e;

  // All widths are in 10 us ticks.
  localparam logic [7:0] START_MIN_TICKS    = 8'd200;
  localparam logic [7:0] GAP_MAX_TICKS      = 8'd200;
  localparam logic [7:0] BIT_ONE_MIN_TICKS  = 8'd90;
  localparam logic [7:0] BIT_ZERO_MIN_TICKS = 8'd40;
  localparam logic [7:0] CARSEL_TOL_TICKS   = 8'd15;

  localparam logic [7:0] CARSEL_BLUE_TICKS   = 8'd130;
  localparam logic [7:0] CARSEL_YELLOW_TICKS = 8'd60;
  localparam logic [7:0] CARSEL_GREEN_TICKS  = 8'd120;
  localparam logic [7:0] CARSEL_RED_TICKS    = 8'd80;

  localparam logic [7:0] REG_CMD_OFS    = 8'd0;
  localparam logic [7:0] REG_STATUS_OFS = 8'd1;

  function automatic logic [7:0] carsel_nominal(input logic [1:0] colour);
    case (colour)
      2'd0:    return CARSEL_BLUE_TICKS;
      2'd1:    return CARSEL_YELLOW_TICKS;
      2'd2:    return CARSEL_GREEN_TICKS;
      default: return CARSEL_RED_TICKS;
    endcase
  endfunction

endpackage

// File: rtl/ir_pulse_meter.sv
// rtl/ir_pulse_meter.sv - IR input synchroniser, tick prescaler and burst/gap width meter.
// Optional 3-of-5 tick majority filter under IR_RX_GLITCH_FILTER_EN.
module ir_pulse_meter
  import ir_rx_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic       burst_start,
  output logic       burst_end,
  output logic       gap_timeout,
  output logic [7:0] width
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             level;
  logic             level_q;
  logic [7:0]       width_q;

  // Idle line is high, so the synchroniser resets to 1 to avoid a phantom burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      div_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], ir_in};
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  assign tick = (div_q == DIV_LAST);

`ifdef IR_RX_GLITCH_FILTER_EN
  logic [4:0] hist_q;
  logic [2:0] ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '1;
    end else if (tick) begin
      hist_q <= {hist_q[3:0], sync_q[1]};
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < 5; i++) begin
      ones = ones + {2'b00, hist_q[i]};
    end
  end

  assign level = (ones >= 3'd3);
`else
  assign level = sync_q[1];
`endif

  // A tick landing on the edge cycle belongs to the new interval, keeping widths exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      width_q <= '0;
    end else begin
      level_q <= level;
      if (level != level_q) begin
        width_q <= tick ? 8'd1 : 8'd0;
      end else if (tick && (width_q != 8'hFF)) begin
        width_q <= width_q + 8'd1;
      end
    end
  end

  assign burst_start = level_q & ~level;
  assign burst_end   = ~level_q & level;
  assign gap_timeout = level & (width_q > GAP_MAX_TICKS);
  assign width       = width_q;

endmodule

// File: rtl/ir_receiver.sv
// rtl/ir_receiver.sv - IR car-command receiver: packet FSM, CMD/STATUS bus registers, interrupt.
// Define IR_RX_GLITCH_FILTER_EN to enable the input majority filter in ir_pulse_meter.
module ir_receiver
  import ir_rx_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter int         TICK_DIV  = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [1:0] COLOUR_COUNTER,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [7:0] CMD_ADDR    = BASE_ADDR + REG_CMD_OFS;
  localparam logic [7:0] STATUS_ADDR = BASE_ADDR + REG_STATUS_OFS;

  logic       burst_start;
  logic       burst_end;
  logic       gap_timeout;
  logic [7:0] width;

  ir_state_e  state_q, state_d;
  logic [3:0] cmd_sh_q, cmd_d;
  logic [1:0] bit_cnt_q, bit_cnt_d;
  logic       done;
  logic [7:0] nominal;
  logic       carsel_ok;

  logic [7:0] cmd_q;
  logic       valid_q;
  logic       overrun_q;
  logic       enable_q;
  logic       rd_en_q;
  logic [7:0] rd_data_q;
  logic [7:0] status;
  logic       rd_cmd;
  logic       rd_hit;
  logic       wr_status;
  logic       unused_wr_bits;

  ir_pulse_meter #(
    .TICK_DIV (TICK_DIV)
  ) u_meter (
    .clk         (CLK),
    .rst_n       (RESET),
    .ir_in       (IR_IN),
    .burst_start (burst_start),
    .burst_end   (burst_end),
    .gap_timeout (gap_timeout),
    .width       (width)
  );

  assign nominal   = carsel_nominal(COLOUR_COUNTER);
  assign carsel_ok = (width >= (nominal - CARSEL_TOL_TICKS)) &&
                     (width <= (nominal + CARSEL_TOL_TICKS));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      cmd_sh_q  <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_sh_q  <= cmd_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_sh_q;
    bit_cnt_d = bit_cnt_q;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (burst_start) state_d = ST_START;
      end
      ST_START: begin
        if (burst_end) state_d = (width >= START_MIN_TICKS) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (burst_start)      state_d = ST_CARSEL;
        else if (gap_timeout) state_d = ST_IDLE;
      end
      ST_CARSEL: begin
        if (burst_end) state_d = carsel_ok ? ST_BITGAP : ST_IDLE;
      end
      ST_BITGAP: begin
        if (burst_start)      state_d = ST_BIT;
        else if (gap_timeout) state_d = ST_IDLE;
      end
      ST_BIT: begin
        if (burst_end) begin
          if (width < BIT_ZERO_MIN_TICKS) begin
            state_d = ST_IDLE;
          end else begin
            cmd_d     = {cmd_sh_q[2:0], (width >= BIT_ONE_MIN_TICKS)};
            bit_cnt_d = bit_cnt_q + 2'd1;
            state_d   = (bit_cnt_q == 2'd3) ? ST_DONE : ST_BITGAP;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A disabled receiver drops whatever it was collecting.
    if (!enable_q) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end
  end

  assign status    = {enable_q, 5'b00000, overrun_q, valid_q};
  assign rd_hit    = !BUS_WE && ((BUS_ADDR == CMD_ADDR) || (BUS_ADDR == STATUS_ADDR));
  assign rd_cmd    = !BUS_WE && (BUS_ADDR == CMD_ADDR);
  assign wr_status = BUS_WE && (BUS_ADDR == STATUS_ADDR);
  assign unused_wr_bits = ^{BUS_DATA[6:2], BUS_DATA[0]};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cmd_q               <= 8'h00;
      valid_q             <= 1'b0;
      overrun_q           <= 1'b0;
      enable_q            <= 1'b1;
      BUS_INTERRUPT_RAISE <= 1'b0;
      rd_en_q             <= 1'b0;
      rd_data_q           <= 8'h00;
    end else begin
      if (done) begin
        cmd_q   <= {COLOUR_COUNTER, 2'b00, cmd_sh_q};
        valid_q <= 1'b1;
      end else if (rd_cmd) begin
        valid_q <= 1'b0;
      end

      if (done && valid_q)                overrun_q <= 1'b1;
      else if (wr_status && BUS_DATA[1])  overrun_q <= 1'b0;

      if (wr_status) enable_q <= BUS_DATA[7];

      if (done)                   BUS_INTERRUPT_RAISE <= 1'b1;
      else if (BUS_INTERRUPT_ACK) BUS_INTERRUPT_RAISE <= 1'b0;

      rd_en_q <= rd_hit;
      if (rd_hit) rd_data_q <= rd_cmd ? cmd_q : status;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_ir_receiver.sv
// tb/tb_ir_receiver.sv - directed self-checking bench for ir_receiver.
module tb_ir_receiver;
  import ir_rx_pkg::*;

  localparam int TD = 2;
  localparam logic [7:0] CMD_A = 8'hA0;
  localparam logic [7:0] STS_A = 8'hA1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir_in = 1'b1;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr = 8'h00;
  logic       bus_we = 1'b0;
  logic [7:0] bus_drv = 8'h00;
  logic       bus_drv_en = 1'b0;
  logic [1:0] colour = 2'd0;
  logic       raise;
  logic       ack = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] rd;

  assign bus_data = bus_drv_en ? bus_drv : 8'hzz;

  ir_receiver #(
    .BASE_ADDR (8'hA0),
    .TICK_DIV  (TD)
  ) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .IR_IN               (ir_in),
    .BUS_DATA            (bus_data),
    .BUS_ADDR            (bus_addr),
    .BUS_WE              (bus_we),
    .COLOUR_COUNTER      (colour),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  task automatic burst(input int n);
    ir_in = 1'b0;
    wait_ticks(n);
    ir_in = 1'b1;
  endtask

  task automatic space(input int n);
    ir_in = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_packet(input int st, input int cs, input int b0, input int b1,
                             input int b2, input int b3, input int gap2);
    burst(st); space(110); burst(cs); space(50);
    burst(b0); space(50); burst(b1); space(gap2);
    burst(b2); space(50); burst(b3); space(50);
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    bus_addr = addr;
    bus_we   = 1'b0;
    @(negedge clk);
    bus_addr = 8'h00;
    data     = bus_data;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_addr   = addr;
    bus_we     = 1'b1;
    bus_drv    = data;
    bus_drv_en = 1'b1;
    @(negedge clk);
    bus_we     = 1'b0;
    bus_drv_en = 1'b0;
    bus_addr   = 8'h00;
  endtask

  task automatic read_expect(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus_read(addr, rd);
    check(tag, {24'h0, rd}, {24'h0, exp});
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    check(tag, {31'h0, raise}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_raise", {31'h0, raise}, 32'h0);
    check("rst_bus_idle", {31'h0, dut.rd_en_q}, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_ticks(5);
    read_expect("rst_status", STS_A, 8'h80);
    read_expect("rst_cmd", CMD_A, 8'h00);

    // Basic packet: blue, bits 1010
    send_packet(240, 130, 100, 45, 100, 45, 50);
    check("pkt_raise", {31'h0, raise}, 32'h1);
    read_expect("pkt_status_valid", STS_A, 8'h81);
    read_expect("pkt_cmd", CMD_A, 8'h0A);
    read_expect("pkt_status_clear", STS_A, 8'h80);
    do_ack("pkt_ack");

    // Wrong car-select width for colour 0
    send_packet(240, 60, 100, 45, 100, 45, 50);
    check("carsel_bad_raise", {31'h0, raise}, 32'h0);
    check("carsel_bad_state", 32'(dut.state_q), 32'(ST_IDLE));
    read_expect("carsel_bad_status", STS_A, 8'h80);

    // Other colours
    colour = 2'd1;
    send_packet(240, 60, 45, 100, 100, 45, 50);
    check("yellow_raise", {31'h0, raise}, 32'h1);
    read_expect("yellow_cmd", CMD_A, 8'h46);
    do_ack("yellow_ack");
    colour = 2'd3;
    send_packet(240, 80, 100, 100, 100, 100, 50);
    read_expect("red_cmd", CMD_A, 8'hCF);
    do_ack("red_ack");
    colour = 2'd0;

    // Overrun and write-1-to-clear
    send_packet(240, 130, 100, 45, 100, 45, 50);
    send_packet(240, 130, 100, 45, 100, 45, 50);
    read_expect("ovr_status", STS_A, 8'h83);
    bus_write(STS_A, 8'h82);
    read_expect("ovr_cleared", STS_A, 8'h81);
    read_expect("ovr_cmd", CMD_A, 8'h0A);
    do_ack("ovr_ack");

    // CMD is read-only
    bus_write(CMD_A, 8'hFF);
    read_expect("cmd_ro", CMD_A, 8'h0A);

    // Gap timeout after second bit, then recovery
    send_packet(240, 130, 100, 45, 100, 45, 210);
    check("gap_to_raise", {31'h0, raise}, 32'h0);
    check("gap_to_state", 32'(dut.state_q), 32'(ST_IDLE));
    send_packet(240, 130, 45, 100, 45, 100, 50);
    check("gap_rec_raise", {31'h0, raise}, 32'h1);
    read_expect("gap_rec_cmd", CMD_A, 8'h05);
    do_ack("gap_rec_ack");

    // Width thresholds
    send_packet(199, 130, 100, 45, 100, 45, 50);
    check("start199_raise", {31'h0, raise}, 32'h0);
    send_packet(240, 114, 100, 45, 100, 45, 50);
    check("carsel114_raise", {31'h0, raise}, 32'h0);
    send_packet(240, 130, 100, 39, 100, 45, 50);
    check("bit39_raise", {31'h0, raise}, 32'h0);
    send_packet(200, 145, 90, 89, 90, 89, 50);
    check("edges_raise", {31'h0, raise}, 32'h1);
    read_expect("edges_cmd", CMD_A, 8'h0A);
    do_ack("edges_ack");

    // Disabled receiver ignores packets
    bus_write(STS_A, 8'h00);
    read_expect("dis_status", STS_A, 8'h00);
    send_packet(240, 130, 100, 45, 100, 45, 50);
    check("dis_raise", {31'h0, raise}, 32'h0);
    read_expect("dis_status2", STS_A, 8'h00);
    bus_write(STS_A, 8'h80);

    // Reset during a bit burst
    send_packet(240, 130, 100, 45, 100, 45, 50);
    check("pre_rst_raise", {31'h0, raise}, 32'h1);
    burst(240); space(110); burst(130); space(50); burst(100); space(50);
    ir_in = 1'b0;
    wait_ticks(20);
    check("mid_state_bit", 32'(dut.state_q), 32'(ST_BIT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_raise", {31'h0, raise}, 32'h0);
    check("mid_rst_bus_idle", {31'h0, dut.rd_en_q}, 32'h0);
    check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(80);
    space(60);
    check("post_rst_raise", {31'h0, raise}, 32'h0);
    read_expect("post_rst_status", STS_A, 8'h80);
    read_expect("post_rst_cmd", CMD_A, 8'h00);

    // One-tick glitch inside the start burst
    burst(120); space(1); burst(119); space(110); burst(130); space(50);
    burst(100); space(50); burst(45); space(50); burst(100); space(50); burst(45); space(50);
`ifdef IR_RX_GLITCH_FILTER_EN
    check("glitch_raise", {31'h0, raise}, 32'h1);
    read_expect("glitch_cmd", CMD_A, 8'h0A);
`else
    check("glitch_raise", {31'h0, raise}, 32'h0);
    read_expect("glitch_status", STS_A, 8'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
